// File: rtl/led_flash_pkg.sv
// ============================================================================
// Module  : led_flash_pkg
// Purpose : Shared types and constants for the LED flash sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package led_flash_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  localparam logic MODE_ALL   = 1'b0;
  localparam logic MODE_CHASE = 1'b1;

  localparam int unsigned CLK_FREQ_HZ = 50000000;

endpackage

`default_nettype wire

// File: rtl/led_flash_seq_phase_timer.sv
// ============================================================================
// Module  : phase_timer
// Purpose : Phase counter shared by ON and OFF phases; pulses expire at tc.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;

  assign expire_o = en_i && !load_i && (cnt_q == tc_i);

  // Wrapping to zero on expiry lets the next phase start without a reload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i || expire_o) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_flash_seq.sv
// ============================================================================
// Module  : led_flash_seq
// Purpose : Timed all-flash / chase LED sequencer with start/busy/done.
//           Optional PWM dimming when LED_FLASH_PWM_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_flash_seq
  import led_flash_pkg::*;
#(
  parameter int NUM_LEDS   = 4,
  parameter int ON_CYCLES  = 50000000,
  parameter int OFF_CYCLES = 250000000,
  parameter int CNT_W      = 32,
  parameter int REPEAT_W   = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                stop,
  input  logic                mode,
  input  logic [NUM_LEDS-1:0] led_mask,
  input  logic [REPEAT_W-1:0] repeat_i,
`ifdef LED_FLASH_PWM_EN
  input  logic [7:0]          brightness,
`endif
  output logic                busy,
  output logic                done,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int               IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam longint           CNT_MAX = (longint'(1) << CNT_W) - 1;
  localparam logic [CNT_W-1:0] ON_TC   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_TC  = CNT_W'((OFF_CYCLES > 0) ? OFF_CYCLES - 1 : 0);

  generate
    if (ON_CYCLES < 1) begin : g_err_on
      $error("led_flash_seq: ON_CYCLES must be >= 1");
    end
    if (OFF_CYCLES < 0) begin : g_err_off
      $error("led_flash_seq: OFF_CYCLES must be >= 0");
    end
    if (NUM_LEDS < 1) begin : g_err_leds
      $error("led_flash_seq: NUM_LEDS must be >= 1");
    end
    if ((ON_CYCLES > CNT_MAX) || (OFF_CYCLES > CNT_MAX)) begin : g_err_cnt
      $error("led_flash_seq: CNT_W too narrow for phase lengths");
    end
  endgenerate

  function automatic logic [NUM_LEDS-1:0] pattern(input logic                m,
                                                  input logic [NUM_LEDS-1:0] msk,
                                                  input logic [IDX_W-1:0]    i);
    logic [NUM_LEDS-1:0] oh;
    oh = NUM_LEDS'(1) << i;
    return (m == MODE_CHASE) ? (msk & oh) : msk;
  endfunction

  state_e              state_q;
  logic                mode_q;
  logic [NUM_LEDS-1:0] mask_q;
  logic [NUM_LEDS-1:0] pat_q;
  logic [NUM_LEDS-1:0] leds_q;
  logic [REPEAT_W-1:0] rep_q;
  logic [REPEAT_W-1:0] round_q;
  logic [IDX_W-1:0]    idx_q;
  logic                busy_q;
  logic                done_q;

  logic                accept_d;
  logic                wrap_d;
  logic                round_end_d;
  logic [IDX_W-1:0]    idx_d;
  logic [REPEAT_W-1:0] round_d;
  logic                finish_d;
  logic [NUM_LEDS-1:0] pat_d;
  logic [NUM_LEDS-1:0] start_pat_d;
  logic                adv_d;
  logic                gate_d;
  logic                gate_start_d;
  logic [CNT_W-1:0]    tc_d;
  logic                timer_expire;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i    (clock),
    .rst_ni   (resetn),
    .load_i   ((state_q == IDLE) || stop),
    .en_i     (state_q != IDLE),
    .tc_i     (tc_d),
    .expire_o (timer_expire)
  );

`ifdef LED_FLASH_PWM_EN
  logic [7:0] pwm_q;
  logic [7:0] bright_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pwm_q    <= 8'd0;
      bright_q <= 8'd0;
    end else begin
      pwm_q <= pwm_q + 8'd1;
      if (accept_d) begin
        bright_q <= brightness;
      end
    end
  end

  // leds is registered, so gate against the pwm value of the cycle it is shown.
  assign gate_d       = (pwm_q + 8'd1) < bright_q;
  assign gate_start_d = (pwm_q + 8'd1) < brightness;
`else
  assign gate_d       = 1'b1;
  assign gate_start_d = 1'b1;
`endif

  always_comb begin
    accept_d    = (state_q == IDLE) && start && !stop;
    wrap_d      = (int'(idx_q) == NUM_LEDS - 1);
    round_end_d = (mode_q == MODE_ALL) || wrap_d;
    idx_d       = idx_q;
    if (mode_q == MODE_CHASE) begin
      idx_d = wrap_d ? '0 : idx_q + 1'b1;
    end
    round_d     = round_q + REPEAT_W'(round_end_d);
    finish_d    = round_end_d && (rep_q != '0) && (round_d == rep_q);
    pat_d       = pattern(mode_q, mask_q, idx_d);
    start_pat_d = pattern(mode, led_mask, '0);
    adv_d       = timer_expire &&
                  ((state_q == OFF) || ((state_q == ON) && (OFF_CYCLES == 0)));
    tc_d        = (state_q == OFF) ? OFF_TC : ON_TC;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      mode_q  <= MODE_ALL;
      mask_q  <= '0;
      pat_q   <= '0;
      leds_q  <= '0;
      rep_q   <= '0;
      round_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != IDLE) && stop) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        leds_q  <= '0;
      end else if (adv_d) begin
        if (finish_d) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          leds_q  <= '0;
        end else begin
          state_q <= ON;
          idx_q   <= idx_d;
          round_q <= round_d;
          pat_q   <= pat_d;
          leds_q  <= pat_d & {NUM_LEDS{gate_d}};
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (accept_d) begin
              state_q <= ON;
              mode_q  <= mode;
              mask_q  <= led_mask;
              rep_q   <= repeat_i;
              idx_q   <= '0;
              round_q <= '0;
              busy_q  <= 1'b1;
              pat_q   <= start_pat_d;
              leds_q  <= start_pat_d & {NUM_LEDS{gate_start_d}};
            end
          end
          ON: begin
            if (timer_expire) begin
              state_q <= OFF;
              leds_q  <= '0;
            end else begin
              leds_q <= pat_q & {NUM_LEDS{gate_d}};
            end
          end
          OFF: begin
            leds_q <= '0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            leds_q  <= '0;
          end
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign leds = leds_q;

endmodule

`default_nettype wire

// File: tb/tb_led_flash_seq.sv
// ============================================================================
// Module  : tb_led_flash_seq
// Purpose : Scoreboard bench for led_flash_seq (OFF=6 and OFF=0 instances).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_flash_seq;

  typedef struct {
    logic [3:0] v;
    int         len;
  } seg_t;

  logic       clk     = 1'b0;
  logic       resetn  = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       stop    = 1'b0;
  logic       mode    = 1'b0;
  logic [3:0] mask    = 4'd0;
  logic [3:0] rep     = 4'd0;
  logic       busy_a, done_a, busy_b, done_b;
  logic [3:0] leds_a, leds_b;

  int         tests = 0;
  int         fails = 0;
  logic [5:0] qa[$];
  logic [5:0] qb[$];
  seg_t       segs[$];

  always #5 clk = ~clk;

  led_flash_seq #(
    .NUM_LEDS(4), .ON_CYCLES(4), .OFF_CYCLES(6), .CNT_W(8), .REPEAT_W(4)
  ) dut_a (
    .clock(clk), .resetn(resetn), .start(start_a), .stop(stop), .mode(mode),
    .led_mask(mask), .repeat_i(rep), .busy(busy_a), .done(done_a), .leds(leds_a)
  );

  led_flash_seq #(
    .NUM_LEDS(4), .ON_CYCLES(4), .OFF_CYCLES(0), .CNT_W(8), .REPEAT_W(4)
  ) dut_b (
    .clock(clk), .resetn(resetn), .start(start_b), .stop(stop), .mode(mode),
    .led_mask(mask), .repeat_i(rep), .busy(busy_b), .done(done_b), .leds(leds_b)
  );

  // Monitors: every cycle a DUT shows busy or done, the next expectation is consumed.
  always @(negedge clk) begin
    if (busy_a || done_a) begin
      tests++;
      if (qa.size() == 0) begin
        fails++;
        $display("FAIL mon_a unexpected output busy=%b done=%b leds=%b, required no output",
                 busy_a, done_a, leds_a);
      end else begin
        logic [5:0] e;
        e = qa.pop_front();
        if ({busy_a, done_a, leds_a} !== e)
          begin
            fails++;
            $display("FAIL mon_a t=%0t got busy/done/leds=%b required %b",
                     $time, {busy_a, done_a, leds_a}, e);
          end
      end
    end
  end

  always @(negedge clk) begin
    if (busy_b || done_b) begin
      tests++;
      if (qb.size() == 0) begin
        fails++;
        $display("FAIL mon_b unexpected output busy=%b done=%b leds=%b, required no output",
                 busy_b, done_b, leds_b);
      end else begin
        logic [5:0] e;
        e = qb.pop_front();
        if ({busy_b, done_b, leds_b} !== e) begin
          fails++;
          $display("FAIL mon_b t=%0t got busy/done/leds=%b required %b",
                   $time, {busy_b, done_b, leds_b}, e);
        end
      end
    end
  end

  task automatic add(input logic [3:0] v, input int len);
    seg_t s;
    s.v   = v;
    s.len = len;
    segs.push_back(s);
  endtask

  task automatic expand(input bit to_b, input bit with_done);
    foreach (segs[i]) begin
      for (int k = 0; k < segs[i].len; k++) begin
        if (to_b) qb.push_back({2'b10, segs[i].v});
        else      qa.push_back({2'b10, segs[i].v});
      end
    end
    if (with_done) begin
      if (to_b) qb.push_back(6'b01_0000);
      else      qa.push_back(6'b01_0000);
    end
    segs.delete();
  endtask

  task automatic launch(input bit to_b, input logic m, input logic [3:0] mk,
                        input logic [3:0] r);
    mode = m;
    mask = mk;
    rep  = r;
    if (to_b) start_b = 1'b1;
    else      start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL %s pending expectations=%0d, required 0", name, qa.size() + qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got busy/done/leds=%b required %b", name, got, exp);
    end
  endtask

  initial begin
    #1 resetn = 1'b0;
    #1;
    check("reset_a", {busy_a, done_a, leds_a}, 6'b0);
    check("reset_b", {busy_b, done_b, leds_b}, 6'b0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    // all-flash, two rounds: 20 busy cycles then done
    add(4'b1111, 4); add(4'b0000, 6); add(4'b1111, 4); add(4'b0000, 6);
    expand(1'b0, 1'b1);
    launch(1'b0, 1'b0, 4'b1111, 4'd1 + 4'd1);
    drain("t1_allflash");

    // chase with a dark slot at index 2
    add(4'b0001, 4); add(4'b0000, 6); add(4'b0010, 4); add(4'b0000, 6);
    add(4'b0000, 4); add(4'b0000, 6); add(4'b1000, 4); add(4'b0000, 6);
    expand(1'b0, 1'b1);
    launch(1'b0, 1'b1, 4'b1011, 4'd1);
    drain("t2_chase");

    // continuous, stopped during busy cycle 25
    add(4'b1111, 4); add(4'b0000, 6); add(4'b1111, 4); add(4'b0000, 6);
    add(4'b1111, 4); add(4'b0000, 1);
    expand(1'b0, 1'b0);
    launch(1'b0, 1'b0, 4'b1111, 4'd0);
    repeat (24) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    check("t3_stop", {busy_a, done_a, leds_a}, 6'b0);
    drain("t3_stop_q");
    repeat (2) @(posedge clk);
    #1;
    add(4'b0101, 4); add(4'b0000, 6);
    expand(1'b0, 1'b1);
    launch(1'b0, 1'b0, 4'b0101, 4'd1);
    drain("t3_restart");

    // start and config changes while busy are ignored
    add(4'b0011, 4); add(4'b0000, 6);
    expand(1'b0, 1'b1);
    launch(1'b0, 1'b0, 4'b0011, 4'd1);
    repeat (5) @(posedge clk);
    #1;
    mode    = 1'b1;
    mask    = 4'b1100;
    rep     = 4'd3;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    drain("t4_busy_start");

    // asynchronous reset in the middle of an on-phase
    add(4'b1111, 2);
    expand(1'b0, 1'b0);
    launch(1'b0, 1'b0, 4'b1111, 4'd3);
    @(posedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("t5_async", {busy_a, done_a, leds_a}, 6'b0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t5_post", {busy_a, done_a, leds_a}, 6'b0);
    drain("t5_q");

    // OFF_CYCLES=0 instance: back-to-back chase, done at cycle 17 (after 16 busy)
    add(4'b0001, 4); add(4'b0010, 4); add(4'b0100, 4); add(4'b1000, 4);
    expand(1'b1, 1'b1);
    launch(1'b1, 1'b1, 4'b1111, 4'd1);
    drain("t6_off0");
    check("t6_idle", {busy_b, done_b, leds_b}, 6'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
